// File: rtl/alu_share_arbiter_if.sv
// Request/response channels of both clients plus the shared ALU hookup.
// Optional rsp*_err lines exist only when ALU_ARB_ILLEGAL_OP_EN is defined.
interface alu_share_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 3
);
  logic             req0_valid, req0_ready;
  logic [OP_W-1:0]  req0_op;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic             rsp0_valid, rsp0_ready;
  logic [WIDTH-1:0] rsp0_result;
  logic             rsp0_zero, rsp0_sign;

  logic             req1_valid, req1_ready;
  logic [OP_W-1:0]  req1_op;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic             rsp1_valid, rsp1_ready;
  logic [WIDTH-1:0] rsp1_result;
  logic             rsp1_zero, rsp1_sign;

  logic [OP_W-1:0]  alu_opcode;
  logic [WIDTH-1:0] alu_rega, alu_regb, alu_result;
  logic             alu_zero, alu_sign;
`ifdef ALU_ARB_ILLEGAL_OP_EN
  logic             rsp0_err, rsp1_err;
`endif

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
    output req0_ready, rsp0_valid, rsp0_result, rsp0_zero, rsp0_sign,
    input  req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
    output req1_ready, rsp1_valid, rsp1_result, rsp1_zero, rsp1_sign,
`ifdef ALU_ARB_ILLEGAL_OP_EN
    output rsp0_err, rsp1_err,
`endif
    output alu_opcode, alu_rega, alu_regb,
    input  alu_result, alu_zero, alu_sign
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
    input  req0_ready, rsp0_valid, rsp0_result, rsp0_zero, rsp0_sign,
    output req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
    input  req1_ready, rsp1_valid, rsp1_result, rsp1_zero, rsp1_sign,
`ifdef ALU_ARB_ILLEGAL_OP_EN
    input  rsp0_err, rsp1_err,
`endif
    input  alu_opcode, alu_rega, alu_regb,
    output alu_result, alu_zero, alu_sign
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two valid/ready clients.
// Optional macro ALU_ARB_ILLEGAL_OP_EN: opcodes 110/111 are trapped and answered with err=1.
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_share_arbiter_if.slave  bus,
  output logic                busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t           state_q;
  logic             rr_last_q, gnt_q;
  logic [1:0]       rsp_vld_q;
  logic [OP_W-1:0]  op_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             zero_q, sign_q;

  logic             idle, grant, acc, rsp_rdy;
  logic [OP_W-1:0]  op_in;
  logic [WIDTH-1:0] a_in, b_in;

  assign idle  = (state_q == IDLE);
  // Both requesting: take the port that did not win last time.
  assign grant = bus.req1_valid && (!bus.req0_valid || !rr_last_q);
  assign bus.req0_ready = idle && bus.req0_valid && !grant;
  assign bus.req1_ready = idle && bus.req1_valid &&  grant;
  assign acc     = bus.req0_ready || bus.req1_ready;
  assign op_in   = grant ? bus.req1_op : bus.req0_op;
  assign a_in    = grant ? bus.req1_a  : bus.req0_a;
  assign b_in    = grant ? bus.req1_b  : bus.req0_b;
  assign rsp_rdy = gnt_q ? bus.rsp1_ready : bus.rsp0_ready;

`ifdef ALU_ARB_ILLEGAL_OP_EN
  logic ill_in, ill_q, err_q;
  assign ill_in = (op_in == OP_W'(3'b110)) || (op_in == OP_W'(3'b111));
  assign bus.rsp0_err = err_q && rsp_vld_q[0];
  assign bus.rsp1_err = err_q && rsp_vld_q[1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_last_q <= 1'b1;
      gnt_q     <= 1'b0;
      rsp_vld_q <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      zero_q    <= 1'b0;
      sign_q    <= 1'b0;
`ifdef ALU_ARB_ILLEGAL_OP_EN
      ill_q     <= 1'b0;
      err_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (acc) begin
          gnt_q   <= grant;
          state_q <= ISSUE;
`ifdef ALU_ARB_ILLEGAL_OP_EN
          ill_q   <= ill_in;
          // Trapped opcodes never reach the ALU; its inputs keep the last legal op.
          if (!ill_in) begin
            op_q <= op_in;
            a_q  <= a_in;
            b_q  <= b_in;
          end
`else
          op_q    <= op_in;
          a_q     <= a_in;
          b_q     <= b_in;
`endif
        end
        ISSUE: begin
`ifdef ALU_ARB_ILLEGAL_OP_EN
          if (ill_q) begin
            res_q  <= '0;
            zero_q <= 1'b1;
            sign_q <= 1'b0;
            err_q  <= 1'b1;
          end else begin
            res_q  <= bus.alu_result;
            zero_q <= bus.alu_zero;
            sign_q <= bus.alu_sign;
            err_q  <= 1'b0;
          end
`else
          res_q  <= bus.alu_result;
          zero_q <= bus.alu_zero;
          sign_q <= bus.alu_sign;
`endif
          rsp_vld_q <= gnt_q ? 2'b10 : 2'b01;
          state_q   <= RESP;
        end
        RESP: if (rsp_rdy) begin
          rsp_vld_q <= '0;
          rr_last_q <= gnt_q;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.alu_opcode  = op_q;
  assign bus.alu_rega    = a_q;
  assign bus.alu_regb    = b_q;
  assign bus.rsp0_valid  = rsp_vld_q[0];
  assign bus.rsp1_valid  = rsp_vld_q[1];
  assign bus.rsp0_result = res_q;
  assign bus.rsp1_result = res_q;
  assign bus.rsp0_zero   = zero_q;
  assign bus.rsp1_zero   = zero_q;
  assign bus.rsp0_sign   = sign_q;
  assign bus.rsp1_sign   = sign_q;
  assign busy            = !idle;
endmodule
